// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register index, default parameter values and the
// load-use hazard compare.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MDU_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int DEF_RESET_HOLD  = 2;
  localparam int DEF_MDU_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 32;

  // A load in EX feeds a register the ID instruction really reads; x0 never hazards.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       uses_rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return mem_read && (rd != REG_X0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating performance counters for the hazard controller: load-use
// stall cycles, MDU wait cycles and redirect flushes. Only built when the
// HAZARD_PERF_CNT_EN macro is defined.
module hazard_perf_counters
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_ld_stall,
  input  logic             inc_mdu_wait,
  input  logic             inc_flush,
  output logic [CNT_W-1:0] perf_ld_stall,
  output logic [CNT_W-1:0] perf_mdu_wait,
  output logic [CNT_W-1:0] perf_flush
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] ld_stall_q, ld_stall_d;
  logic [CNT_W-1:0] mdu_wait_q, mdu_wait_d;
  logic [CNT_W-1:0] flush_q,    flush_d;

  // Next counter values: bump on an event, stick at all-ones once saturated.
  always_comb begin
    ld_stall_d = ld_stall_q;
    mdu_wait_d = mdu_wait_q;
    flush_d    = flush_q;
    if (inc_ld_stall && (ld_stall_q != CNT_MAX)) ld_stall_d = ld_stall_q + CNT_ONE;
    if (inc_mdu_wait && (mdu_wait_q != CNT_MAX)) mdu_wait_d = mdu_wait_q + CNT_ONE;
    if (inc_flush    && (flush_q    != CNT_MAX)) flush_d    = flush_q + CNT_ONE;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_stall_q <= '0;
      mdu_wait_q <= '0;
      flush_q    <= '0;
    end else begin
      ld_stall_q <= ld_stall_d;
      mdu_wait_q <= mdu_wait_d;
      flush_q    <= flush_d;
    end
  end

  assign perf_ld_stall = ld_stall_q;
  assign perf_mdu_wait = mdu_wait_q;
  assign perf_flush    = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Handles load-use stalls,
// taken-branch redirects and multi-cycle MUL/DIV occupancy, and holds the
// pipeline flushed for a few cycles after reset.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the performance counters;
// without it the perf_* ports are tied to zero.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RESET_HOLD  = DEF_RESET_HOLD,
  parameter int MDU_TIMEOUT = DEF_MDU_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_Uses_rs1,
  input  logic             IF_ID_Uses_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_IsMDU,
  input  logic             EX_BranchTaken,
  input  logic             mdu_done,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Bubble,
  output logic             mdu_start,
  output logic             mdu_timeout_err,
  output logic [CNT_W-1:0] perf_ld_stall,
  output logic [CNT_W-1:0] perf_mdu_wait,
  output logic [CNT_W-1:0] perf_flush
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int TMR_W  = $clog2(MDU_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(MDU_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);

  hz_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;

  logic load_use;

  assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_Uses_rs1,
                                 IF_ID_rs2, IF_ID_Uses_rs2);

  // Next-state and control outputs; branch beats MDU launch beats load-use in RUN.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    timer_d       = timer_q;
    err_d         = err_q;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    mdu_start     = 1'b0;

    case (state_q)
      ST_HOLD: begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        IF_ID_Flush   = 1'b1;
        ID_EX_Flush   = 1'b1;
        EX_MEM_Bubble = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end

      ST_RUN: begin
        if (EX_BranchTaken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (ID_EX_IsMDU) begin
          mdu_start     = 1'b1;
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
          state_d       = ST_MDU_WAIT;
          timer_d       = TMR_ONE;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end

      ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else if (timer_q == TMR_LAST) begin
          err_d         = 1'b1;
          EX_MEM_Bubble = 1'b1;
          state_d       = ST_RUN;
        end else begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
          timer_d       = timer_q + TMR_ONE;
        end
      end

      default: begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        IF_ID_Flush   = 1'b1;
        ID_EX_Flush   = 1'b1;
        EX_MEM_Bubble = 1'b1;
        state_d       = ST_HOLD;
        hold_cnt_d    = '0;
      end
    endcase
  end

  // State, hold counter, MDU timer and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  assign mdu_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic inc_ld_stall;
  logic inc_mdu_wait;
  logic inc_flush;

  assign inc_ld_stall = (state_q == ST_RUN) && !EX_BranchTaken && !ID_EX_IsMDU && load_use;
  assign inc_mdu_wait = (state_q == ST_MDU_WAIT);
  assign inc_flush    = (state_q == ST_RUN) && EX_BranchTaken;

  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .reset         (reset),
    .inc_ld_stall  (inc_ld_stall),
    .inc_mdu_wait  (inc_mdu_wait),
    .inc_flush     (inc_flush),
    .perf_ld_stall (perf_ld_stall),
    .perf_mdu_wait (perf_mdu_wait),
    .perf_flush    (perf_flush)
  );
`else
  assign perf_ld_stall = '0;
  assign perf_mdu_wait = '0;
  assign perf_flush    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle RUN
// vectors plus hand-written sequences for reset hold, MDU wait, MDU timeout
// and reset during an MDU operation. Counter expectations follow
// HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam int RESET_HOLD  = 2;
  localparam int MDU_TIMEOUT = 6;
  localparam int CNT_W       = 32;

  // Expected control vectors: {PCWrite, IF_ID_Write, ID_EX_Write,
  //                            IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble, mdu_start}
  localparam logic [6:0] HOLD_O  = 7'b000_111_0;
  localparam logic [6:0] RUN_O   = 7'b111_000_0;
  localparam logic [6:0] LDST_O  = 7'b001_010_0;
  localparam logic [6:0] BR_O    = 7'b111_110_0;
  localparam logic [6:0] MDUST_O = 7'b000_001_1;
  localparam logic [6:0] WAIT_O  = 7'b000_001_0;
  localparam logic [6:0] TO_O    = 7'b111_001_0;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       memRd;
    logic       isMdu;
    logic       br;
    logic       done;
    logic [6:0] expOut;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [4:0]       ifIdRs1, ifIdRs2, idExRd;
  logic             usesRs1, usesRs2, idExMemRead, idExIsMdu, exBranchTaken, mduDone;
  logic             pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush, exMemBubble, mduStart;
  logic             mduTimeoutErr;
  logic [CNT_W-1:0] perfLdStall, perfMduWait, perfFlush;

  int checkCount;
  int passCount;
  int ldExp, mduExp, flushExp;
  int startPulses;
  vec_t vecs[$];

  pipeline_hazard_ctrl #(
    .RESET_HOLD  (RESET_HOLD),
    .MDU_TIMEOUT (MDU_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_rs1       (ifIdRs1),
    .IF_ID_rs2       (ifIdRs2),
    .IF_ID_Uses_rs1  (usesRs1),
    .IF_ID_Uses_rs2  (usesRs2),
    .ID_EX_rd        (idExRd),
    .ID_EX_MemRead   (idExMemRead),
    .ID_EX_IsMDU     (idExIsMdu),
    .EX_BranchTaken  (exBranchTaken),
    .mdu_done        (mduDone),
    .PCWrite         (pcWrite),
    .IF_ID_Write     (ifIdWrite),
    .ID_EX_Write     (idExWrite),
    .IF_ID_Flush     (ifIdFlush),
    .ID_EX_Flush     (idExFlush),
    .EX_MEM_Bubble   (exMemBubble),
    .mdu_start       (mduStart),
    .mdu_timeout_err (mduTimeoutErr),
    .perf_ld_stall   (perfLdStall),
    .perf_mdu_wait   (perfMduWait),
    .perf_flush      (perfFlush)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters read zero when the perf feature is compiled out.
  function automatic int perfExp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic vec_t mkVec(input string name, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic memRd, input logic isMdu, input logic br,
                                 input logic done, input logic [6:0] expOut);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.memRd = memRd; v.isMdu = isMdu; v.br = br; v.done = done; v.expOut = expOut;
    return v;
  endfunction

  // Drive one vector onto the DUT inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input vec_t v);
    ifIdRs1       = v.rs1;
    usesRs1       = v.u1;
    ifIdRs2       = v.rs2;
    usesRs2       = v.u2;
    idExRd        = v.rd;
    idExMemRead   = v.memRd;
    idExIsMdu     = v.isMdu;
    exBranchTaken = v.br;
    mduDone       = v.done;
    #1;
  endtask

  task automatic setIdle(input logic isMdu, input logic done);
    applyStimulus(mkVec("idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, isMdu, 1'b0, done, RUN_O));
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expOut);
    logic [6:0] act;
    act = {pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush, exMemBubble, mduStart};
    if (mduStart) startPulses++;
    checkCount++;
    if (act === expOut) passCount++;
    else $display("[TB] FAIL %s: ctrl got %b expected %b", name, act, expOut);
  endtask

  task automatic checkValue(input string name, input logic [CNT_W-1:0] act, input int expVal);
    checkCount++;
    if (act === CNT_W'(expVal)) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, expVal);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the post-reset hold window and arrival in RUN.
  task automatic checkHoldWindow(input string tag);
    setIdle(1'b0, 1'b0);
    for (int i = 0; i < RESET_HOLD; i++) begin
      checkOutput($sformatf("%s_hold%0d", tag, i), HOLD_O);
      step();
    end
    checkOutput($sformatf("%s_run", tag), RUN_O);
  endtask

  initial begin
    checkCount = 0; passCount = 0;
    ldExp = 0; mduExp = 0; flushExp = 0; startPulses = 0;

    vecs.push_back(mkVec("idle",        5'd0,  0, 5'd0, 0, 5'd0,  0, 0, 0, 0, RUN_O));
    vecs.push_back(mkVec("lu_rs2",      5'd1,  0, 5'd5, 1, 5'd5,  1, 0, 0, 0, LDST_O));
    vecs.push_back(mkVec("lu_rd0",      5'd1,  0, 5'd0, 1, 5'd0,  1, 0, 0, 0, RUN_O));
    vecs.push_back(mkVec("lu_nouse2",   5'd1,  0, 5'd5, 0, 5'd5,  1, 0, 0, 0, RUN_O));
    vecs.push_back(mkVec("lu_rs1",      5'd12, 1, 5'd3, 0, 5'd12, 1, 0, 0, 0, LDST_O));
    vecs.push_back(mkVec("lu_nouse1",   5'd12, 0, 5'd3, 1, 5'd12, 1, 0, 0, 0, RUN_O));
    vecs.push_back(mkVec("no_load",     5'd7,  1, 5'd0, 0, 5'd7,  0, 0, 0, 0, RUN_O));
    vecs.push_back(mkVec("br_over_lu",  5'd0,  0, 5'd5, 1, 5'd5,  1, 0, 1, 0, BR_O));
    vecs.push_back(mkVec("br_only",     5'd0,  0, 5'd0, 0, 5'd0,  0, 0, 1, 0, BR_O));
    vecs.push_back(mkVec("done_in_run", 5'd0,  0, 5'd0, 0, 5'd0,  0, 0, 0, 1, RUN_O));
    vecs.push_back(mkVec("lu_both",     5'd9,  1, 5'd9, 1, 5'd9,  1, 0, 0, 0, LDST_O));
    vecs.push_back(mkVec("lu_diff",     5'd31, 1, 5'd2, 1, 5'd30, 1, 0, 0, 0, RUN_O));

    // Reset: hold window then RUN
    reset = 1'b1;
    setIdle(1'b0, 1'b0);
    step();
    checkOutput("in_reset", HOLD_O);
    checkValue("err_reset", CNT_W'(mduTimeoutErr), 0);
    checkValue("perf_ld_reset", perfLdStall, 0);
    reset = 1'b0;
    #1;
    checkHoldWindow("por");
    step();

    // Table of single-cycle RUN vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].expOut);
      if (vecs[i].expOut == LDST_O) ldExp++;
      if (vecs[i].expOut == BR_O) flushExp++;
      step();
    end
    setIdle(1'b0, 1'b0);
    checkOutput("after_table", RUN_O);
    checkValue("perf_ld_stall", perfLdStall, perfExp(ldExp));
    checkValue("perf_flush", perfFlush, perfExp(flushExp));

    // MDU launch, four idle wait cycles, done on the fifth wait cycle
    startPulses = 0;
    setIdle(1'b1, 1'b0);
    checkOutput("mdu_launch", MDUST_O);
    step();
    for (int i = 0; i < 4; i++) begin
      setIdle(1'b0, 1'b0);
      checkOutput($sformatf("mdu_wait%0d", i), WAIT_O);
      mduExp++;
      step();
    end
    setIdle(1'b0, 1'b1);
    checkOutput("mdu_done", RUN_O);
    mduExp++;
    step();
    setIdle(1'b0, 1'b0);
    checkOutput("mdu_back_run", RUN_O);
    checkValue("mdu_start_pulses", CNT_W'(startPulses), 1);
    checkValue("perf_mdu_wait", perfMduWait, perfExp(mduExp));
    step();

    // Done arriving on the timeout cycle wins: no error
    setIdle(1'b1, 1'b0);
    checkOutput("mdu2_launch", MDUST_O);
    step();
    for (int i = 0; i < MDU_TIMEOUT - 1; i++) begin
      setIdle(1'b0, 1'b0);
      checkOutput($sformatf("mdu2_wait%0d", i), WAIT_O);
      mduExp++;
      step();
    end
    setIdle(1'b0, 1'b1);
    checkOutput("mdu2_done_at_limit", RUN_O);
    mduExp++;
    step();
    setIdle(1'b0, 1'b0);
    checkValue("err_after_late_done", CNT_W'(mduTimeoutErr), 0);

    // Timeout: no done at all
    setIdle(1'b1, 1'b0);
    checkOutput("mdu3_launch", MDUST_O);
    step();
    for (int i = 0; i < MDU_TIMEOUT - 1; i++) begin
      setIdle(1'b0, 1'b0);
      checkOutput($sformatf("mdu3_wait%0d", i), WAIT_O);
      checkValue($sformatf("mdu3_err_low%0d", i), CNT_W'(mduTimeoutErr), 0);
      mduExp++;
      step();
    end
    setIdle(1'b0, 1'b0);
    checkOutput("mdu3_timeout", TO_O);
    mduExp++;
    step();
    checkValue("err_set", CNT_W'(mduTimeoutErr), 1);
    checkOutput("after_timeout_run", RUN_O);
    checkValue("perf_mdu_wait2", perfMduWait, perfExp(mduExp));
    for (int i = 0; i < 3; i++) step();
    setIdle(1'b0, 1'b1);
    checkOutput("late_done_ignored", RUN_O);
    checkValue("err_sticky", CNT_W'(mduTimeoutErr), 1);
    step();

    // Reset in the middle of an MDU wait
    setIdle(1'b1, 1'b0);
    checkOutput("mdu4_launch", MDUST_O);
    step();
    setIdle(1'b0, 1'b0);
    checkOutput("mdu4_wait", WAIT_O);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_mdu", HOLD_O);
    checkValue("err_cleared", CNT_W'(mduTimeoutErr), 0);
    checkValue("perf_ld_cleared", perfLdStall, 0);
    checkValue("perf_mdu_cleared", perfMduWait, 0);
    checkValue("perf_flush_cleared", perfFlush, 0);
    step();
    reset = 1'b0;
    #1;
    checkHoldWindow("rst2");
    step();
    setIdle(1'b0, 1'b1);
    checkOutput("done_after_reset_ignored", RUN_O);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
